// File: rtl/sinc_generator_pkg.sv
// Shared definitions for the periodic sync generator.
// Holds the default counter width and the IDLE/RUN state encoding.
package sinc_generator_pkg;

   localparam int unsigned NB_REG_DEFAULT = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sinc_generator_period_counter.sv
// Loadable phase counter that runs 0..prt-1 and wraps to 0.
// It exposes its next value and a terminal-count flag so the parent can reload its shadow registers.
module period_counter
   import sinc_generator_pkg::*;
#(
   parameter int unsigned NB_REG = NB_REG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [NB_REG-1:0] i_prt,
   output logic [NB_REG-1:0] o_phase_nxt_c,
   output logic              o_tc_c
);

   logic [NB_REG-1:0] r_phase;
   logic [NB_REG-1:0] w_phase_nxt;

   assign o_tc_c = (r_phase == (i_prt - NB_REG'(1)));

   // Clear has priority; at terminal count the phase wraps, so it never exceeds prt-1.
   always_comb begin
      w_phase_nxt = r_phase;
      if (i_clr) begin
         w_phase_nxt = '0;
      end else if (i_en) begin
         w_phase_nxt = o_tc_c ? '0 : (r_phase + NB_REG'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_phase <= '0;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   assign o_phase_nxt_c = w_phase_nxt;

endmodule

// File: rtl/sinc_generator.sv
// Periodic sync pulse generator: sinc is high for t_q of every prt_q clock cycles.
// Period and width are shadowed at each period boundary, so mid-period input changes wait for the next period.
module sinc_generator
   import sinc_generator_pkg::*;
#(
   parameter int unsigned NB_REG = NB_REG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NB_REG-1:0] PRT_count_wire,
   input  logic [NB_REG-1:0] T_count_wire,
   output logic              sinc
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [NB_REG-1:0] r_prt;
   logic [NB_REG-1:0] r_t;
   logic [NB_REG-1:0] w_prt_nxt;
   logic [NB_REG-1:0] w_t_nxt;
   logic              r_sinc;
   logic              w_sinc_nxt;
   logic              w_clr;
   logic              w_en;
   logic              w_tc;
   logic [NB_REG-1:0] w_phase_nxt;

   period_counter #(
      .NB_REG (NB_REG)
   ) u_period_counter (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (w_clr),
      .i_en          (w_en),
      .i_prt         (r_prt),
      .o_phase_nxt_c (w_phase_nxt),
      .o_tc_c        (w_tc)
   );

   // Next-state logic; sinc is precomputed from the phase and width that will hold after the edge.
   always_comb begin
      w_state_nxt = r_state;
      w_prt_nxt   = r_prt;
      w_t_nxt     = r_t;
      w_sinc_nxt  = 1'b0;
      w_clr       = 1'b1;
      w_en        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (PRT_count_wire != '0)) begin
               w_state_nxt = ST_RUN;
               w_prt_nxt   = PRT_count_wire;
               w_t_nxt     = T_count_wire;
               w_sinc_nxt  = (T_count_wire != '0);
            end
         end
         ST_RUN: begin
            if (!start) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_clr = 1'b0;
               w_en  = 1'b1;
               if (w_tc) begin
                  w_prt_nxt = PRT_count_wire;
                  w_t_nxt   = T_count_wire;
                  if (PRT_count_wire == '0) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_sinc_nxt = (T_count_wire != '0);
                  end
               end else begin
                  w_sinc_nxt = (w_phase_nxt < r_t);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_prt   <= '0;
         r_t     <= '0;
         r_sinc  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prt   <= w_prt_nxt;
         r_t     <= w_t_nxt;
         r_sinc  <= w_sinc_nxt;
      end
   end

   assign sinc = r_sinc;

endmodule

// File: tb/tb_sinc_generator.sv
// Directed self-checking bench for sinc_generator.
// Each step drives inputs just after a rising edge and checks sinc 1 time unit after the next one.
module tb_sinc_generator;

   localparam int unsigned NB = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [NB-1:0] prt;
   logic [NB-1:0] t;
   logic          sinc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sinc_generator #(
      .NB_REG (NB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .PRT_count_wire (prt),
      .T_count_wire   (t),
      .sinc           (sinc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Run n cycles; after the i-th edge the phase is (ph0+i) mod p and sinc must equal phase < tw.
   task automatic run_chk(input string tag, input int n, input int ph0, input int p, input int tw);
      for (int i = 0; i < n; i++) begin
         tick();
         chk($sformatf("%s[%0d]", tag, i), sinc, (((ph0 + i) % p) < tw) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic stop_run(input string tag);
      start = 1'b0;
      tick();
      chk(tag, sinc, 1'b0);
   endtask

   initial begin
      int rises;
      int highs;
      int rise_at [2];
      logic prev;

      // Reset overrides start
      rst   = 1'b0;
      start = 1'b1;
      prt   = 10;
      t     = 3;
      tick();
      chk("reset", sinc, 1'b0);
      tick();
      chk("reset_hold", sinc, 1'b0);

      // Small values: 3 high, 7 low, first rise one edge after start sampled
      rst = 1'b1;
      run_chk("small", 30, 0, 10, 3);

      // Reconfiguration mid-period takes effect next period
      stop_run("abort_pre_reconf");
      start = 1'b1;
      run_chk("reconf_a", 2, 0, 10, 3);
      t = 5;
      run_chk("reconf_cur", 8, 2, 10, 3);
      run_chk("reconf_next", 10, 0, 10, 5);
      t = 3;
      run_chk("reconf_back", 10, 0, 10, 3);

      // Abort at phase 1, restart 4 cycles later
      stop_run("abort_pre_restart");
      start = 1'b1;
      run_chk("abort_a", 2, 0, 10, 3);
      start = 1'b0;
      tick();
      chk("abort_drop", sinc, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("abort_idle[%0d]", i), sinc, 1'b0);
      end
      start = 1'b1;
      run_chk("restart", 12, 0, 10, 3);

      // Reset while at phase 1 of a pulse
      rst = 1'b0;
      tick();
      chk("rst_mid_drop", sinc, 1'b0);
      tick();
      chk("rst_mid_hold", sinc, 1'b0);
      rst = 1'b1;
      run_chk("post_rst", 12, 0, 10, 3);

      // T=0: never rises
      stop_run("abort_pre_t0");
      t     = 0;
      start = 1'b1;
      run_chk("t0", 25, 0, 10, 0);

      // T>=PRT: constant high across period boundaries
      stop_run("abort_pre_t12");
      t     = 12;
      start = 1'b1;
      run_chk("t12", 25, 0, 10, 12);

      // PRT=0: stays idle
      stop_run("abort_pre_prt0");
      prt   = 0;
      t     = 3;
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("prt0_idle[%0d]", i), sinc, 1'b0);
      end

      // Leaving idle when PRT becomes nonzero, then PRT reloaded as 0 returns to idle
      prt = 10;
      run_chk("from_prt0", 4, 0, 10, 3);
      prt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk($sformatf("prt_reload0[%0d]", i), sinc, 1'b0);
      end
      prt = 4;
      t   = 1;
      run_chk("prt4", 8, 0, 4, 1);

      // PRT=1: one-cycle period
      stop_run("abort_pre_prt1");
      prt   = 1;
      t     = 1;
      start = 1'b1;
      run_chk("prt1_t1", 5, 0, 1, 1);
      t = 0;
      run_chk("prt1_t0", 5, 0, 1, 0);

      // Nominal timing scaled by 1/1024: 2400-cycle period, 264-cycle pulse, window of 1.15 periods
      stop_run("abort_pre_nom");
      prt        = 2400;
      t          = 264;
      start      = 1'b1;
      rises      = 0;
      highs      = 0;
      rise_at[0] = -1;
      rise_at[1] = -1;
      prev       = 1'b0;
      for (int i = 0; i < 2760; i++) begin
         tick();
         if (sinc === 1'b1 && prev === 1'b0) begin
            if (rises < 2) rise_at[rises] = i;
            rises++;
         end
         if (sinc === 1'b1) highs++;
         prev = sinc;
      end
      chk_int("nom_rises", rises, 2);
      chk_int("nom_high_cycles", highs, 528);
      chk_int("nom_rise0_at", rise_at[0], 0);
      chk_int("nom_rise1_at", rise_at[1], 2400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
